// File: rtl/alu_pkg.sv
// Shared opcode/state encodings and opcode classification helpers for the
// multi-cycle ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_SHR1 = 4'd0,
    OP_SHL1 = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_ADD  = 4'd6,
    OP_SUB  = 4'd7,
    OP_SHLN = 4'd8,
    OP_MUL  = 4'd9,
    OP_CMP  = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Opcodes at or above this value are reserved and flagged with err.
  localparam logic [3:0] OP_ILLEGAL_MIN = 4'd11;

  function automatic logic is_serial_op(input logic [3:0] op);
    return (op == OP_SHLN) || (op == OP_MUL);
  endfunction

  function automatic logic is_illegal_op(input logic [3:0] op);
    return op >= OP_ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Operand/result handshake bundle between the register-file side (master)
// and the ALU (slave).
interface alu_multicycle_if #(
  parameter int WIDTH = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic             cout;
  logic             sign;
  logic             ov;
  logic             zero;
  logic             err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, z, cout, sign, ov, zero, err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, z, cout, sign, ov, zero, err
  );
endinterface

// File: rtl/alu_comb_core.sv
// Single-cycle ALU operations (opcodes 0-7 and CMP). For CMP the difference
// is returned on o_z so the caller can derive sign/zero before masking z.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_z,
  output logic             o_cout,
  output logic             o_ov
);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_z    = '0;
    o_cout = 1'b0;
    o_ov   = 1'b0;
    case (i_op)
      OP_SHR1: begin
        o_z    = i_a >> 1;
        o_cout = i_a[0];
      end
      OP_SHL1: begin
        o_z    = i_b << 1;
        o_cout = i_b[MSB];
      end
      OP_AND: o_z = i_a & i_b;
      OP_OR:  o_z = i_a | i_b;
      OP_XOR: o_z = i_a ^ i_b;
      OP_NOT: o_z = ~i_a;
      OP_ADD: begin
        o_z    = w_sum[MSB:0];
        o_cout = w_sum[WIDTH];
        o_ov   = (i_a[MSB] == i_b[MSB]) & (w_sum[MSB] != i_a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        // Bit WIDTH of the zero-extended difference is the unsigned borrow.
        o_z    = w_diff[MSB:0];
        o_cout = w_diff[WIDTH];
        o_ov   = (i_a[MSB] != i_b[MSB]) & (w_diff[MSB] != i_a[MSB]);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with valid/ready handshake: single-cycle ops finish on the
// accept edge, SHLN and MUL iterate one bit per cycle in the BUSY state.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic            clk,
  input logic            rst,
  alu_multicycle_if.slave bus
);
  localparam int MSB = WIDTH - 1;
  localparam int CW  = SHW + 1;

  state_e r_state;
  state_e w_state_next;

  logic             w_in_ready;
  logic             w_load_single;
  logic             w_start_serial;
  logic             w_finish;
  logic             w_illegal;

  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;

  logic [WIDTH-1:0] r_z;
  logic             r_cout;
  logic             r_sign;
  logic             r_ov;
  logic             r_zero;
  logic             r_err;

  logic [WIDTH-1:0]   w_core_z;
  logic               w_core_cout;
  logic               w_core_ov;
  logic [WIDTH-1:0]   w_sh_next;
  logic               w_sh_cout;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH-1:0]   w_ser_z;
  logic               w_ser_cout;

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .i_op   (bus.op),
    .i_a    (bus.a),
    .i_b    (bus.b),
    .o_z    (w_core_z),
    .o_cout (w_core_cout),
    .o_ov   (w_core_ov)
  );

  assign w_illegal = is_illegal_op(bus.op);

  // A zero shift count still spends one BUSY cycle but leaves the operand intact.
  assign w_sh_next = (r_cnt != '0) ? {r_acc[MSB-1:0], 1'b0} : r_acc[MSB:0];
  assign w_sh_cout = (r_cnt != '0) & r_acc[MSB];

  // Shift-add: multiplier sits in the low half, partial product grows in the high half.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[MSB:1]};

  assign w_ser_z    = (r_op == OP_MUL) ? w_mul_next[MSB:0] : w_sh_next;
  assign w_ser_cout = (r_op == OP_MUL) ? (|w_mul_next[2*WIDTH-1:WIDTH]) : w_sh_cout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_in_ready     = 1'b0;
    w_load_single  = 1'b0;
    w_start_serial = 1'b0;
    w_finish       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_in_ready = (r_state == S_IDLE) | bus.out_ready;
        if (w_in_ready && bus.in_valid) begin
          if (is_serial_op(bus.op)) begin
            w_start_serial = 1'b1;
            w_state_next   = S_BUSY;
          end else begin
            w_load_single = 1'b1;
            w_state_next  = S_DONE;
          end
        end else if (r_state == S_DONE && bus.out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      S_BUSY: begin
        if (r_cnt <= CW'(1)) begin
          w_finish     = 1'b1;
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= '0;
      r_a    <= '0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_z    <= '0;
      r_cout <= 1'b0;
      r_sign <= 1'b0;
      r_ov   <= 1'b0;
      r_zero <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_start_serial) begin
        r_op  <= bus.op;
        r_a   <= bus.a;
        r_cnt <= (bus.op == OP_MUL) ? CW'(WIDTH) : {1'b0, bus.b[SHW-1:0]};
        r_acc <= (bus.op == OP_MUL) ? {{WIDTH{1'b0}}, bus.b} : {{WIDTH{1'b0}}, bus.a};
      end else if (r_state == S_BUSY) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - CW'(1);
        end
        r_acc <= (r_op == OP_MUL) ? w_mul_next : {{WIDTH{1'b0}}, w_sh_next};
      end

      if (w_load_single) begin
        // CMP keeps sign/zero of the difference but never writes a result.
        r_z    <= (w_illegal || bus.op == OP_CMP) ? '0 : w_core_z;
        r_cout <= w_core_cout;
        r_ov   <= w_core_ov;
        r_sign <= w_core_z[MSB];
        r_zero <= !w_illegal && (w_core_z == '0);
        r_err  <= w_illegal;
      end else if (w_finish) begin
        r_z    <= w_ser_z;
        r_cout <= w_ser_cout;
        r_ov   <= 1'b0;
        r_sign <= w_ser_z[MSB];
        r_zero <= (w_ser_z == '0);
        r_err  <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.z         = r_z;
  assign bus.cout      = r_cout;
  assign bus.sign      = r_sign;
  assign bus.ov        = r_ov;
  assign bus.zero      = r_zero;
  assign bus.err       = r_err;

endmodule
